// File: rtl/sipo_frame_deserializer.sv
// Serial-in/parallel-out audio frame deserializer: CHANNELS words of runtime
// length and bit order, extended to WIDTH bits, delivered over valid/ready.
module sipo_frame_deserializer #(
   parameter int WIDTH       = 32,
   parameter int CHANNELS    = 2,
   parameter bit SIGN_EXTEND = 1'b1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       enable,
   input  logic                       in,
   input  logic                       frame_start,
   input  logic [$clog2(WIDTH+1)-1:0] word_len,
   input  logic                       msb_first,
   output logic [CHANNELS*WIDTH-1:0]  out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       overrun,
   output logic                       resync_err
);

   localparam int LW = $clog2(WIDTH+1);
   localparam int CW = $clog2(CHANNELS+1);
   localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);
   localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS-1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                    state;
   logic [LW-1:0]             len;
   logic                      msb;
   logic [LW-1:0]             bit_cnt;
   logic [CW-1:0]             ch_cnt;
   logic [WIDTH-1:0]          work;
   logic [CHANNELS*WIDTH-1:0] frame_q;

   logic                      in_shift;
   logic                      frame_end_shift;
   logic                      start;
   logic                      resync;
   logic                      active;
   logic [LW-1:0]             len_clamp;
   logic [LW-1:0]             cur_len;
   logic                      cur_msb;
   logic [LW-1:0]             cur_bit;
   logic [LW-1:0]             bit_next;
   logic [LW-1:0]             pos;
   logic [CW-1:0]             cur_ch;
   logic                      word_done;
   logic                      frame_done;
   logic [WIDTH-1:0]          word_next;
   logic [WIDTH-1:0]          mask;
   logic [WIDTH-1:0]          top;
   logic [WIDTH-1:0]          ext;
   logic [CHANNELS*WIDTH-1:0] frame_next;

   always_comb begin
      len_clamp = (word_len == '0 || word_len > LEN_MAX) ? LEN_MAX : word_len;
      in_shift  = (state == SHIFT);
      // a frame_start on the final bit of a frame is consumed by the completion
      frame_end_shift = in_shift && (bit_cnt + 1'b1 == len) && (ch_cnt == CH_LAST);
      start  = enable && frame_start && !frame_end_shift;
      resync = start && in_shift;
      active = enable && (in_shift || start);

      cur_len  = start ? len_clamp : len;
      cur_msb  = start ? msb_first : msb;
      cur_bit  = start ? '0 : bit_cnt;
      cur_ch   = start ? '0 : ch_cnt;
      bit_next = cur_bit + 1'b1;
      pos      = cur_msb ? cur_len - bit_next : cur_bit;

      word_next  = (start ? '0 : work) | (WIDTH'(in) << pos);
      word_done  = active && (bit_next == cur_len);
      frame_done = word_done && (cur_ch == CH_LAST);

      // mask covers the live bits, top isolates the word's sign bit
      mask = ~({WIDTH{1'b1}} << cur_len);
      top  = mask ^ (mask >> 1);
      ext  = word_next & mask;
      if (SIGN_EXTEND && |(word_next & top))
         ext = ext | ~mask;

      frame_next = frame_q;
      for (int k = 0; k < CHANNELS; k++)
         if (cur_ch == CW'(k))
            frame_next[k*WIDTH +: WIDTH] = ext;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         len        <= '0;
         msb        <= 1'b0;
         bit_cnt    <= '0;
         ch_cnt     <= '0;
         work       <= '0;
         frame_q    <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         resync_err <= 1'b0;
      end else begin
         resync_err <= resync;
         if (start) begin
            len <= len_clamp;
            msb <= msb_first;
         end
         if (active) begin
            if (word_done) begin
               bit_cnt <= '0;
               work    <= '0;
               frame_q <= frame_next;
               ch_cnt  <= frame_done ? '0 : cur_ch + 1'b1;
               state   <= frame_done ? IDLE : SHIFT;
            end else begin
               bit_cnt <= bit_next;
               work    <= word_next;
               ch_cnt  <= cur_ch;
               state   <= SHIFT;
            end
         end
         if (frame_done) begin
            if (!out_valid || out_ready) begin
               out_data  <= frame_next;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/sipo_frame_deserializer.md
Name: sipo_frame_deserializer

Overview:
- Parametrised serial-in/parallel-out deserializer for multi-channel audio frames (I2S/TDM-style bit streams).
- Collects CHANNELS words per frame, each up to WIDTH bits, with a runtime word length and bit order.
- Sign-extends each word and delivers the whole frame as one parallel bus over a valid/ready handshake.
- Sits between a serial audio receiver front end and the sample-processing pipeline.

Parameters:
- WIDTH, 32: maximum word width in bits, and the width of each output channel slot.
- CHANNELS, 2: number of words per frame.
- SIGN_EXTEND, 1: 1 = replicate the word MSB into unused upper bits; 0 = zero-fill them.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- enable  in  1  bit strobe; `in` and `frame_start` are sampled only when enable=1
- in  in  1  serial data bit
- frame_start  in  1  qualified by enable; marks bit 0 of channel 0
- word_len  in  $clog2(WIDTH+1)  bits per word; latched on frame_start
- msb_first  in  1  bit order; latched on frame_start
- out_data  out  CHANNELS*WIDTH  frame; channel k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts the frame
- overrun  out  1  sticky; a completed frame was dropped
- resync_err  out  1  one-cycle pulse; frame_start arrived mid-frame

Behaviour:
- Reset (rstn=0 at a clk edge): out_data=0, out_valid=0, overrun=0, resync_err=0, state=IDLE, counters=0. Reset wins over all other inputs. Reset mid-frame discards the partial frame.
- Clocked state machine with two states, IDLE and SHIFT.
- IDLE:
  - Ignores bits until a cycle with enable=1 and frame_start=1.
  - That bit is bit 0 of channel 0.
  - Latches word_len and msb_first; word_len of 0 or greater than WIDTH is clamped to WIDTH.
  - Sets bit_cnt=1, ch_cnt=0, moves to SHIFT.
- SHIFT: each enable=1 cycle shifts one bit into the working register and increments bit_cnt.
  - LSB-first: the first bit received lands at word bit 0.
  - MSB-first: the first bit received lands at word bit L-1, where L is the latched word length.
- Word completion: when bit_cnt reaches L on an enable cycle:
  - The aligned word, with bits [WIDTH-1:L] sign-extended or zero-filled per SIGN_EXTEND, is written to frame buffer slot ch_cnt.
  - bit_cnt resets to 0 and ch_cnt increments.
- Frame completion: on the cycle the last word of channel CHANNELS-1 completes, the state returns to IDLE.
  - The next frame needs a new frame_start; continuous streams must assert frame_start on the first bit of every frame.
- frame_start during SHIFT (enable=1):
  - The partial frame is discarded and resync_err pulses high for exactly the next cycle.
  - The current bit becomes bit 0 of channel 0 of a new frame; word_len and msb_first are re-latched.
  - Exception: if the cycle also completes a frame, the completion is processed first and no resync_err is raised.
- Bits arriving when enable=0 have no effect; `in` and `frame_start` are ignored.
- Output handshake:
  - At the edge sampling the final bit, if out_valid=0 or out_ready=1: out_data <= buffer and out_valid <= 1. Latency is 0 cycles after the last bit edge, so out_valid is visible the cycle after.
  - If out_valid=1 and out_ready=0 at completion: the new frame is dropped, out_data is held, and overrun <= 1.
  - overrun stays high until reset.
  - out_valid=1 and out_ready=1 with no completing frame: out_valid <= 0 and out_data is held.
  - While out_valid=1, out_data must not change until the handshake completes.
- word_len and msb_first changes mid-frame have no effect until the next frame_start.
- Counter widths are $clog2(WIDTH+1) for bit_cnt and $clog2(CHANNELS+1) for ch_cnt; neither counter may wrap.

Test Plan:
1. LSB-first, WIDTH=8, CHANNELS=2, word_len=8, out_ready=1; send frame_start plus 0xA5 LSB-first, then 0x3C -> out_data=16'h3CA5, out_valid high for 1 cycle.
2. MSB-first, word_len=4, SIGN_EXTEND=1; ch0 bits 1,0,1,1 and ch1 bits 0,1,1,0 -> out_data=16'h06FB. Repeat with SIGN_EXTEND=0 -> 16'h060B.
3. Backpressure with out_ready=0: frame 1 (16'h1234) is held; frame 2 (16'h5678) completes -> overrun=1, out_data stays 16'h1234. Raise out_ready -> out_valid drops next cycle.
4. Simultaneous: out_ready=1 on the same edge as frame 2's last bit -> out_data=16'h5678, out_valid stays 1, overrun stays 0.
5. Resync: frame_start on bit 5 of ch0 -> resync_err pulses exactly 1 cycle; the following full frame 16'hBEEF is delivered intact.
6. Reset mid-frame after 3 bits, then a clean frame 16'hC001 -> all outputs 0 during reset, the partial frame is discarded, 16'hC001 is delivered. Also apply enable=0 gaps between bits -> identical result.
